// File: rtl/tt_um_and.sv
// Registered 8-bit AND unit (mask / accumulate / load-mask / reduce) for a TinyTapeout tile.
// Define AND_POPCOUNT_EN to replace the status flags on uio_out[7:4] with popcount(R).
module tt_um_and (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    MODE_MASK = 2'b00,
    MODE_ACC  = 2'b01,
    MODE_LOAD = 2'b10,
    MODE_RED  = 2'b11
  } mode_e;

  logic [7:0] r_q, r_d;
  logic [7:0] k_q, k_d;
  logic       v_q, v_d;

  mode_e mode;
  logic  en;
  logic  clr;

  assign mode = mode_e'(uio_in[1:0]);
  assign en   = uio_in[2];
  assign clr  = uio_in[3];

  // clr wins over en; LOAD only touches the mask, so R and V are left alone.
  always_comb begin
    r_d = r_q;
    k_d = k_q;
    v_d = v_q;
    if (ena) begin
      if (clr) begin
        r_d = '1;
        v_d = 1'b0;
      end else if (en) begin
        unique case (mode)
          MODE_MASK: begin
            r_d = ui_in & k_q;
            v_d = 1'b1;
          end
          MODE_ACC: begin
            r_d = r_q & ui_in;
            v_d = 1'b1;
          end
          MODE_LOAD: begin
            k_d = ui_in;
          end
          MODE_RED: begin
            r_d = {7'b0, &ui_in};
            v_d = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
      k_q <= '1;
      v_q <= 1'b0;
    end else begin
      r_q <= r_d;
      k_q <= k_d;
      v_q <= v_d;
    end
  end

  logic [3:0] status;

`ifdef AND_POPCOUNT_EN
  always_comb begin
    status = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      status = status + {3'b0, r_q[i]};
    end
  end
`else
  always_comb begin
    status[0] = (r_q == 8'h00);
    status[1] = (r_q == 8'hFF);
    status[2] = &r_q;
    status[3] = v_q;
  end
`endif

  assign uo_out  = r_q;
  assign uio_out = {status, 4'b0000};
  assign uio_oe  = 8'hF0;

  logic unused_uio_hi;
  assign unused_uio_hi = &{1'b0, uio_in[7:4]};

endmodule

// File: tb/tb_tt_um_and.sv
// Self-checking bench for tt_um_and: directed vectors plus randomized traffic against a byte-level model.
module tb_tt_um_and;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state
  logic [7:0] m_r;
  logic [7:0] m_k;
  logic       m_v;

  tt_um_and dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
  endtask

  function automatic logic [7:0] exp_status();
    logic [7:0] s;
`ifdef AND_POPCOUNT_EN
    int cnt;
    cnt = $countones(m_r);
    s = {cnt[3:0], 4'b0000};
`else
    s = {m_v, (m_r == 8'hFF), (m_r == 8'hFF), (m_r == 8'h00), 4'b0000};
`endif
    return s;
  endfunction

  task automatic model_edge(input logic rst, input logic en_t, input logic clr,
                            input logic en, input logic [1:0] m, input logic [7:0] a);
    if (!rst) begin
      m_r = 8'h00; m_k = 8'hFF; m_v = 1'b0;
    end else if (en_t) begin
      if (clr) begin
        m_r = 8'hFF; m_v = 1'b0;
      end else if (en) begin
        if (m == 2'd0) begin m_r = a & m_k; m_v = 1'b1; end
        else if (m == 2'd1) begin m_r = m_r & a; m_v = 1'b1; end
        else if (m == 2'd2) m_k = a;
        else begin m_r = (a == 8'hFF) ? 8'h01 : 8'h00; m_v = 1'b1; end
      end
    end
  endtask

  task automatic step(input logic rst, input logic en_t, input logic clr,
                      input logic en, input logic [1:0] m, input logic [7:0] a);
    logic [3:0] junk;
    junk   = 4'($urandom);
    rst_n  = rst;
    ena    = en_t;
    ui_in  = a;
    uio_in = {junk, clr, en, m};
    @(posedge clk);
    #1;
    model_edge(rst, en_t, clr, en, m, a);
    check("uo_out", uo_out, m_r);
    check("uio_out", uio_out, exp_status());
    check("uio_oe", uio_oe, 8'hF0);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; ui_in = '0; uio_in = '0;
    m_r = '0; m_k = '1; m_v = 1'b0;
    @(negedge clk);

    step(0, 1, 0, 0, 2'd0, 8'h00);
    step(0, 1, 0, 0, 2'd0, 8'h00);
    check("rst_uo", uo_out, 8'h00);
`ifdef AND_POPCOUNT_EN
    check("rst_uio", uio_out, 8'h00);
`else
    check("rst_uio", uio_out, 8'h10);
`endif

    step(1, 1, 0, 1, 2'd0, 8'hA5);
    check("mask_ff", uo_out, 8'hA5);
    step(1, 1, 0, 1, 2'd2, 8'h0F);
    check("load_keeps_r", uo_out, 8'hA5);
    step(1, 1, 0, 1, 2'd0, 8'hA5);
    check("mask_0f", uo_out, 8'h05);

    step(1, 1, 1, 0, 2'd0, 8'h00);
    check("clr_r", uo_out, 8'hFF);
    step(1, 1, 0, 1, 2'd1, 8'hF3);
    check("acc1", uo_out, 8'hF3);
`ifdef AND_POPCOUNT_EN
    check("pop_f3", uio_out, 8'h60);
`endif
    step(1, 1, 0, 1, 2'd1, 8'h3E);
    check("acc2", uo_out, 8'h32);

    step(1, 1, 0, 1, 2'd3, 8'hFF);
    check("red_ff", uo_out, 8'h01);
    step(1, 1, 0, 1, 2'd3, 8'hFE);
    check("red_fe", uo_out, 8'h00);

    step(1, 1, 1, 1, 2'd0, 8'h00);
    check("clr_prio", uo_out, 8'hFF);
`ifdef AND_POPCOUNT_EN
    check("pop_ff", uio_out, 8'h80);
`else
    check("clr_flags", uio_out, 8'h60);
`endif
    step(1, 0, 0, 1, 2'd0, 8'h00);
    check("ena_hold", uo_out, 8'hFF);
    step(1, 1, 0, 0, 2'd1, 8'h00);
    check("en_hold", uo_out, 8'hFF);
    step(1, 1, 0, 1, 2'd1, 8'h7C);
    step(0, 1, 0, 1, 2'd1, 8'h0F);
    check("rst_mid_acc", uo_out, 8'h00);

    for (int i = 0; i < 400; i++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      step(($urandom_range(0, 40) != 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 9) == 0), 1'($urandom), 2'($urandom), a);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
